// File: rtl/parity_tx.sv
// Parity encoder with a 2-entry skid buffer between a valid/grant upstream and downstream.
// Adds one parity bit per word, with a one-shot parity-corruption hook and a transfer counter.
module parity_tx #(
    parameter int unsigned DATA_WIDTH = 17,
    parameter logic        PARITY     = 1'b1,
    parameter logic        P_BIT      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  grant_out,
    input  logic [DATA_WIDTH-2:0] payload_in,
    output logic                  valid_out,
    input  logic                  grant_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  err_inject,
    output logic                  inj_pending,
    output logic [15:0]           tx_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] skid;
    logic                  accept;
    logic                  xfer;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] enc_word;

    assign accept = valid_in & grant_out;
    assign xfer   = valid_out & grant_in;

    // Encoded form of the incoming payload, parity inverted when an injection is due.
    always_comb begin
        par_bit  = (PARITY ? ^payload_in : ~^payload_in) ^ (err_inject | inj_pending);
        enc_word = P_BIT ? {payload_in, par_bit} : {par_bit, payload_in};
    end

    // data_out doubles as the head entry so it holds its value once the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            grant_out   <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            skid        <= '0;
            inj_pending <= 1'b0;
            tx_count    <= '0;
        end else begin
            if (xfer) begin
                tx_count <= tx_count + 16'd1;
            end
            if (accept) begin
                inj_pending <= 1'b0;
            end else if (err_inject) begin
                inj_pending <= 1'b1;
            end

            case (state)
                EMPTY: begin
                    grant_out <= 1'b1;
                    valid_out <= accept;
                    if (accept) begin
                        data_out <= enc_word;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, xfer})
                        2'b11: begin
                            data_out  <= enc_word;
                            grant_out <= 1'b1;
                            valid_out <= 1'b1;
                        end
                        2'b10: begin
                            skid      <= enc_word;
                            state     <= TWO;
                            grant_out <= 1'b0;
                            valid_out <= 1'b1;
                        end
                        2'b01: begin
                            state     <= EMPTY;
                            grant_out <= 1'b1;
                            valid_out <= 1'b0;
                        end
                        default: begin
                            grant_out <= 1'b1;
                            valid_out <= 1'b1;
                        end
                    endcase
                end
                TWO: begin
                    valid_out <= 1'b1;
                    if (xfer) begin
                        data_out  <= skid;
                        state     <= ONE;
                        grant_out <= 1'b1;
                    end else begin
                        grant_out <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    grant_out <= 1'b1;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: three configurations (even/LSB, odd/LSB, even/MSB) driven in lockstep
// and compared each cycle against a queue-based model, plus fixed vectors and corner sequences.
module tb_parity_tx;

    localparam int unsigned DW = 17;
    localparam int unsigned PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          grant_in;
    logic          err_inject;
    logic [PW-1:0] payload_in;

    logic          grant_el, grant_ol, grant_em;
    logic          valid_el, valid_ol, valid_em;
    logic          inj_el, inj_ol, inj_em;
    logic [DW-1:0] data_el, data_ol, data_em;
    logic [15:0]   tx_el, tx_ol, tx_em;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_tx #(.DATA_WIDTH(DW), .PARITY(1'b1), .P_BIT(1'b1)) u_el (
        .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_el),
        .payload_in(payload_in), .valid_out(valid_el), .grant_in(grant_in),
        .data_out(data_el), .err_inject(err_inject), .inj_pending(inj_el), .tx_count(tx_el)
    );
    parity_tx #(.DATA_WIDTH(DW), .PARITY(1'b0), .P_BIT(1'b1)) u_ol (
        .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_ol),
        .payload_in(payload_in), .valid_out(valid_ol), .grant_in(grant_in),
        .data_out(data_ol), .err_inject(err_inject), .inj_pending(inj_ol), .tx_count(tx_ol)
    );
    parity_tx #(.DATA_WIDTH(DW), .PARITY(1'b1), .P_BIT(1'b0)) u_em (
        .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_em),
        .payload_in(payload_in), .valid_out(valid_em), .grant_in(grant_in),
        .data_out(data_em), .err_inject(err_inject), .inj_pending(inj_em), .tx_count(tx_em)
    );

    // Reference model: words in flight as {flip, payload}, encoded on demand per configuration.
    logic [PW:0] q[$];
    logic [PW:0] m_last;
    bit          m_has_last;
    bit          m_grant;
    bit          m_pend;
    int          m_tx;

    function automatic logic [DW-1:0] enc(logic [PW:0] e, int cfg);
        int   ones;
        logic p;
        ones = $countones(e[PW-1:0]);
        if (cfg == 1) p = (ones % 2 == 0) ? 1'b1 : 1'b0;
        else          p = (ones % 2 == 1) ? 1'b1 : 1'b0;
        p = p ^ e[PW];
        if (cfg == 2) return {p, e[PW-1:0]};
        return {e[PW-1:0], p};
    endfunction

    function automatic logic [DW-1:0] exp_data(int cfg);
        if (q.size() > 0) return enc(q[0], cfg);
        if (m_has_last)   return enc(m_last, cfg);
        return '0;
    endfunction

    task automatic model_update();
        bit acc, xf, flip;
        if (rst) begin
            q.delete();
            m_grant = 0; m_pend = 0; m_tx = 0; m_has_last = 0;
        end else begin
            acc  = valid_in && m_grant;
            xf   = (q.size() > 0) && grant_in;
            flip = err_inject || m_pend;
            if (xf) begin
                m_last     = q.pop_front();
                m_has_last = 1;
                m_tx       = (m_tx + 1) % 65536;
            end
            if (acc) begin
                q.push_back({flip, payload_in});
                m_pend = 0;
            end else if (err_inject) begin
                m_pend = 1;
            end
            m_grant = (q.size() < 2);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] g, v;
        g = {31'd0, m_grant};
        v = {31'd0, (q.size() > 0) ? 1'b1 : 1'b0};
        chk("grant_el", 32'(grant_el), g);
        chk("grant_ol", 32'(grant_ol), g);
        chk("grant_em", 32'(grant_em), g);
        chk("valid_el", 32'(valid_el), v);
        chk("valid_ol", 32'(valid_ol), v);
        chk("valid_em", 32'(valid_em), v);
        chk("inj_el", 32'(inj_el), {31'd0, m_pend});
        chk("inj_em", 32'(inj_em), {31'd0, m_pend});
        chk("tx_el", 32'(tx_el), 32'(m_tx));
        chk("tx_ol", 32'(tx_ol), 32'(m_tx));
        chk("data_el", 32'(data_el), 32'(exp_data(0)));
        chk("data_ol", 32'(data_ol), 32'(exp_data(1)));
        chk("data_em", 32'(data_em), 32'(exp_data(2)));
    endtask

    // One clock: inputs are already set; model steps at the edge, DUT sampled at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; grant_in = 1'b0; err_inject = 1'b0;
        cycle();
        chk("rst_grant", 32'(grant_el), 32'd0);
        chk("rst_valid", 32'(valid_el), 32'd0);
        chk("rst_data", 32'(data_el), 32'd0);
        chk("rst_tx", 32'(tx_el), 32'd0);
        rst = 1'b0;
        cycle();
        chk("grant_after_rst", 32'(grant_el), 32'd1);
    endtask

    typedef struct {
        logic [PW-1:0] pl;
        logic [DW-1:0] e_el;
        logic [DW-1:0] e_ol;
        logic [DW-1:0] e_em;
    } vec_t;

    vec_t vecs[5];

    initial begin
        rst = 1'b1; valid_in = 1'b0; grant_in = 1'b0; err_inject = 1'b0; payload_in = '0;
        vecs[0] = '{16'h0001, 17'h00003, 17'h00002, 17'h10001};
        vecs[1] = '{16'h0003, 17'h00006, 17'h00007, 17'h00003};
        vecs[2] = '{16'h0000, 17'h00000, 17'h00001, 17'h00000};
        vecs[3] = '{16'hFFFF, 17'h1FFFE, 17'h1FFFF, 17'h0FFFF};
        vecs[4] = '{16'h8000, 17'h10001, 17'h10000, 17'h18000};

        do_reset();

        // Fixed encodings, one word per cycle with grant_in high.
        grant_in = 1'b1;
        foreach (vecs[i]) begin
            valid_in = 1'b1; payload_in = vecs[i].pl;
            cycle();
            chk("vec_valid", 32'(valid_el), 32'd1);
            chk("vec_el", 32'(data_el), 32'(vecs[i].e_el));
            chk("vec_ol", 32'(data_ol), 32'(vecs[i].e_ol));
            chk("vec_em", 32'(data_em), 32'(vecs[i].e_em));
        end
        valid_in = 1'b0;
        cycle();
        chk("vec_tx", 32'(tx_el), 32'd5);

        // Backpressure: A and B fill the buffer, C is held until the drain.
        do_reset();
        grant_in = 1'b0; valid_in = 1'b1;
        payload_in = 16'h00AA; cycle();
        payload_in = 16'h0055; cycle();
        chk("bp_grant_low", 32'(grant_el), 32'd0);
        chk("bp_head_a", 32'(data_el), 32'h00154);
        payload_in = 16'h1234; cycle();
        chk("bp_c_held", 32'(grant_el), 32'd0);
        chk("bp_a_stable", 32'(data_el), 32'h00154);
        grant_in = 1'b1; cycle();
        chk("bp_b", 32'(data_el), 32'h000AA);
        chk("bp_grant_back", 32'(grant_el), 32'd1);
        cycle();
        chk("bp_c", 32'(data_el), 32'h02469);
        valid_in = 1'b0; cycle();
        chk("bp_tx3", 32'(tx_el), 32'd3);

        // Injection: pulse, then two zero payloads.
        do_reset();
        grant_in = 1'b1; err_inject = 1'b1; cycle();
        err_inject = 1'b0;
        chk("inj_armed", 32'(inj_el), 32'd1);
        cycle();
        chk("inj_still", 32'(inj_el), 32'd1);
        valid_in = 1'b1; payload_in = 16'h0000; cycle();
        chk("inj_word", 32'(data_el), 32'h00001);
        chk("inj_cleared", 32'(inj_el), 32'd0);
        cycle();
        chk("inj_clean", 32'(data_el), 32'h00000);
        err_inject = 1'b1; cycle();
        err_inject = 1'b0;
        chk("inj_same_cycle", 32'(data_el), 32'h00001);
        chk("inj_same_nopend", 32'(inj_el), 32'd0);
        valid_in = 1'b0; cycle();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            valid_in   = ($urandom_range(0, 3) != 0);
            grant_in   = ($urandom_range(0, 2) != 0);
            err_inject = ($urandom_range(0, 15) == 0);
            payload_in = PW'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; err_inject = 1'b0;

        // Counter wrap: stream until the count reaches FFFF, then one more transfer.
        grant_in = 1'b1; valid_in = 1'b1;
        for (int n = 0; n < 70000 && m_tx != 16'hFFFF; n++) begin
            payload_in = PW'($urandom);
            cycle();
        end
        chk("wrap_ffff", 32'(tx_el), 32'h0000FFFF);
        valid_in = 1'b0;
        cycle();
        chk("wrap_zero", 32'(tx_el), 32'd0);

        // Reset with the buffer full.
        grant_in = 1'b0; valid_in = 1'b1;
        cycle(); cycle();
        chk("two_full", 32'(grant_el), 32'd0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_tx.md
# parity_tx

Producer-side counterpart of the parity-checked FIFO path. It accepts raw payload words over a valid/grant handshake and computes a parity bit per word. It inserts that bit at the configured position and presents the encoded word downstream on a valid/grant handshake. The downstream target is the checked FIFO's push side. A 2-entry skid buffer keeps grant_out registered and sustains one word per cycle. A parity error-injection hook and a transfer counter support system-level checker verification.

## Interface
- DATA_WIDTH, 17, encoded word width; the payload is DATA_WIDTH-1 bits.
- PARITY, 1'b1, 1'b1 = even parity over the full encoded word, 1'b0 = odd.
- P_BIT, 1'b1, parity bit position:
  - 1'b1: LSB; data_out = {payload, p}.
  - 1'b0: MSB; data_out = {p, payload}.
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream word valid.
- grant_out  output  1  upstream may transfer; registered.
- payload_in  input  DATA_WIDTH-1  raw payload.
- valid_out  output  1  encoded word valid.
- grant_in  input  1  downstream accepts.
- data_out  output  DATA_WIDTH  encoded word.
- err_inject  input  1  single-cycle request to corrupt the parity of one word.
- inj_pending  output  1  an injection is armed but not yet applied.
- tx_count  output  16  number of downstream transfers, modulo 2^16.

## Operation
- Upstream accept: valid_in && grant_out at a rising edge.
- Downstream transfer: valid_out && grant_in at a rising edge.
- Parity bit p:
  - Even (PARITY=1): p = ^payload, so the popcount of the encoded word is even.
  - Odd (PARITY=0): p = ~^payload.
- The bit is computed at accept time and stored with the payload.
- Buffer: two entries, head and skid, with occupancy states EMPTY, ONE and TWO.
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept plus transfer.
  - ONE -> TWO on accept without transfer.
  - ONE -> EMPTY on transfer without accept.
  - TWO -> ONE on transfer; no accept is possible in TWO.
- data_out is always the oldest stored word. Strict FIFO order; no word is dropped or duplicated.
- valid_out = 1 in ONE and TWO.
- grant_out (registered) = 1 when the next state is EMPTY or ONE.
- Error injection:
  - A pulse on err_inject sets inj_pending.
  - The next accepted word gets p inverted, and inj_pending clears on that accept.
  - If err_inject is high in the same cycle as an accept, that word is corrupted and inj_pending stays 0.
  - Further pulses while pending are absorbed: only one word is corrupted.
- tx_count increments by 1 on each downstream transfer and wraps from 16'hFFFF to 0.
- Outputs never go X. When valid_out=0, data_out holds its last value (0 after reset).

## Timing
- Reset values: grant_out=0, valid_out=0, data_out=0, inj_pending=0, tx_count=0, state EMPTY.
- grant_out rises in the first cycle after rst deasserts.
- Latency: a word accepted at edge N appears on data_out/valid_out after edge N (one-cycle latency). There is no combinational path from payload_in to data_out.
- grant_out has no combinational dependence on grant_in; it is a one-cycle-late view of occupancy.
- Throughput: one word per cycle while grant_in stays high.
- Backpressure:
  - With grant_in low, two words are accepted; grant_out drops after the edge that fills TWO.
  - With grant_in high again, grant_out returns high one cycle after the first drain.
- Data stability: data_out and valid_out hold while valid_out=1 and grant_in=0.
- Reset mid-operation: on the edge where rst=1, both entries are discarded, inj_pending clears and tx_count clears. Input handshakes in that cycle are ignored.

## Test plan
- Even parity, LSB position (defaults), payload 16'h0001, grant_in=1 -> data_out=17'h00003 with valid_out high one cycle after accept, then tx_count=1.
- Odd parity, LSB position (PARITY=0), payload 16'h0001 -> data_out=17'h00002.
- Even parity, MSB position (P_BIT=0):
  - payload 16'h0001 -> data_out=17'h10001.
  - payload 16'h0003 -> data_out=17'h00003.
- Backpressure: grant_in=0, offer A=16'h00AA, B=16'h0055, C=16'h1234 back-to-back:
  - A and B are accepted; grant_out=0 and C is held.
  - After grant_in=1, data_out emits A, B, C on consecutive cycles with correct parity, and tx_count=3.
- Injection (even, LSB):
  - err_inject pulse, then payloads 0x0000 and 0x0000 -> data_out = 17'h00001, then 17'h00000.
  - inj_pending is high from the pulse until the first accept.
- Reset and wrap:
  - Preload tx_count to 16'hFFFF via transfers, then one more transfer -> tx_count=0.
  - Assert rst with the buffer in TWO -> next cycle valid_out=0, grant_out=0, tx_count=0; grant_out=1 one cycle after release.
